line_mem_responder: RTL and testbench
=====================================

Name: line_mem_responder

Overview:
- Memory-side responder for the cache line bus: mem_read/mem_write, 28-bit line address, 128-bit data, mem_ready.
- Serves one 4-word line per request after a fixed, programmable latency.
- Used as the backing store behind the instruction and data caches in simulation, and as the on-chip line RAM in the FPGA build.
- The cache side drops its request in the same cycle mem_ready is high. The responder sees this as a one-cycle ready pulse.

Parameters:
- ADDR_W, 8: number of line-index bits. Storage is 2^ADDR_W lines of 128 bits; mem_addr[27:ADDR_W] is ignored, so upper addresses alias.
- LATENCY, 4: cycles from request accept to mem_ready. Legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  read request, level, held until mem_ready.
- mem_write  input  1  write request, level, held until mem_ready.
- mem_addr  input  28  line address, word address >> 2.
- mem_wdata  input  128  write line; word0 in [31:0].
- mem_rdata  output  128  read line, registered.
- mem_ready  output  1  one-cycle completion pulse, registered.
- proto_err  output  1  sticky protocol-error flag.
- rd_cnt  output  16  completed reads (MEM_STATS_EN only, else 0).
- wr_cnt  output  16  completed writes (MEM_STATS_EN only, else 0).

Behaviour:
- Reset: synchronous, active-high, sampled on the clk rising edge. rst high clears:
  - state to IDLE; all storage lines to 0;
  - mem_rdata=0, mem_ready=0, proto_err=0, rd_cnt=0, wr_cnt=0;
  - latency counter to 0.
  - Reset mid-transaction aborts it: no write commit, no ready.
- States:
  - IDLE -> WAIT when mem_read or mem_write is high. On that edge, latch op, index = mem_addr[ADDR_W-1:0], wdata, and load counter = LATENCY-1.
  - WAIT: decrement the counter each cycle. When counter==0 and the request is still asserted -> RESP.
  - RESP: mem_ready=1 for exactly this cycle.
    - Read: mem_rdata = mem[index].
    - Write: mem[index] <= latched wdata at the end of this cycle.
    - Always -> IDLE.
- Timing: request first seen high at edge N -> mem_ready high in the cycle following edge N+LATENCY. A new request can be accepted at the edge that ends the RESP cycle +1, i.e. one IDLE cycle minimum between transactions.
- Latched values are used throughout. Changes to mem_addr or mem_wdata during WAIT are ignored.
- Request dropped in WAIT (mem_read and mem_write both low): abort -> IDLE. No ready, no write commit, proto_err set.
- mem_read and mem_write both high at accept: the write is served, proto_err set.
- mem_rdata holds the last read line outside RESP. Writes do not change mem_rdata.
- Read-after-write to the same index in consecutive transactions returns the new data, because the write commits before the next accept.
- proto_err clears only on rst.

Optional Feature:
- MEM_STATS_EN defined:
  - rd_cnt increments on each read RESP cycle; wr_cnt increments on each write RESP cycle.
  - Both counters saturate at 16'hFFFF.
  - Aborted requests do not count.
- MEM_STATS_EN undefined: rd_cnt and wr_cnt tied to 0, no counter flops.

Test Plan:
- Reset then read addr 28'h5 (LATENCY=4): mem_ready is a single pulse 4 cycles after accept, and mem_rdata=128'h0.
- Write 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D to addr 28'h12, then read 28'h12 -> same value.
- Read 28'h112 with ADDR_W=8 -> returns the 28'h12 data (aliasing).
- Read 28'h3 and deassert mem_read after 2 WAIT cycles -> no mem_ready, proto_err=1, and the next read works normally.
- mem_read=mem_write=1 with wdata=128'h1 to addr 28'h7 -> proto_err=1, one ready; a subsequent read of 28'h7 returns 128'h1.
- MEM_STATS_EN build: 3 reads, 2 writes, 1 aborted read -> rd_cnt=3, wr_cnt=2. Assert rst mid-WAIT of a write -> no commit, and all outputs return to 0.

Source files
------------

// File: rtl/line_mem_responder.sv
// line_mem_responder
//   Memory-side responder for the cache line bus. Each request is served one
//   128-bit line (4 words) after a fixed, programmable latency. The storage
//   holds 2^ADDR_W lines. Upper address bits are ignored, so addresses alias.
//
//   Optional feature macro: MEM_STATS_EN
//     When defined, rd_cnt and wr_cnt count completed reads and writes. Both
//     counters saturate at 16'hFFFF.
//     When undefined, both counters are tied to 0 and no counter flops exist.
//
//   Ports
//     clk        in   1    clock, rising edge
//     rst        in   1    synchronous active-high reset
//     mem_read   in   1    read request (level, held until mem_ready)
//     mem_write  in   1    write request (level, held until mem_ready)
//     mem_addr   in   28   line address (word address >> 2)
//     mem_wdata  in   128  write line, word0 in [31:0]
//     mem_rdata  out  128  read line, registered, holds last read
//     mem_ready  out  1    one-cycle completion pulse, registered
//     proto_err  out  1    sticky protocol-error flag
//     rd_cnt     out  16   completed reads (MEM_STATS_EN), else 0
//     wr_cnt     out  16   completed writes (MEM_STATS_EN), else 0
module line_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         proto_err,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wr_cnt
);

  localparam int unsigned Lines = 1 << ADDR_W;
  localparam logic [7:0] CntLoad = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [127:0]        wdata_q, wdata_d;
  logic [127:0]        rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                perr_q, perr_d;
  logic [127:0]        mem_q [Lines];

  logic req;
  assign req = mem_read | mem_write;

  // Upper address bits alias onto the same lines.
  if (ADDR_W < 28) begin : g_addr_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[27:ADDR_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    perr_d  = perr_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StWait;
          op_wr_d = mem_write;  // write wins when both are high
          idx_d   = mem_addr[ADDR_W-1:0];
          wdata_d = mem_wdata;
          cnt_d   = CntLoad;
          if (mem_read && mem_write) perr_d = 1'b1;
        end
      end
      StWait: begin
        if (!req) begin
          // Request withdrawn before completion: abort silently, flag it.
          state_d = StIdle;
          perr_d  = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d = StResp;
          if (!op_wr_q) rdata_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
      for (int i = 0; i < Lines; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      perr_q  <= perr_d;
      // Commit at the end of RESP so a back-to-back read sees the new line.
      if (state_q == StResp && op_wr_q) mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign proto_err = perr_q;

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == StResp) begin
      if (op_wr_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 16'h0;
  assign wr_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder (ADDR_W=8, LATENCY=4).
module tb_line_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         proto_err;
  logic [15:0]  rd_cnt, wr_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int hits;

  localparam logic [127:0] LineD = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] LineE = 128'h0F0F0F0F_11112222_33334444_55556666;

`ifdef MEM_STATS_EN
  localparam logic [15:0] ExpRd = 16'd5;
  localparam logic [15:0] ExpWr = 16'd2;
  localparam logic [15:0] ExpRdAfter = 16'd1;
`else
  localparam logic [15:0] ExpRd = 16'd0;
  localparam logic [15:0] ExpWr = 16'd0;
  localparam logic [15:0] ExpRdAfter = 16'd0;
`endif

  always #5 clk = ~clk;

  line_mem_responder #(
    .ADDR_W  (8),
    .LATENCY (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .proto_err (proto_err),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request: accept, scramble addr/wdata during WAIT, wait for ready,
  // drop the request in the ready cycle, then confirm the pulse is single.
  task automatic txn(input logic rd, input logic wr, input logic [27:0] a,
                     input logic [127:0] wd, input string tag);
    int cyc;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = wd;
    @(posedge clk);
    #1;
    mem_addr  = '1;
    mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_ready === 1'b1) break;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    chk({tag, "_latency"}, 128'(cyc), 128'd4);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 128'(mem_ready), 128'd0);
  endtask

  initial begin
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_rdata", mem_rdata, 128'd0);
    chk("rst_ready", 128'(mem_ready), 128'd0);
    chk("rst_perr", 128'(proto_err), 128'd0);
    chk("rst_rdcnt", 128'(rd_cnt), 128'd0);
    chk("rst_wrcnt", 128'(wr_cnt), 128'd0);

    txn(1'b1, 1'b0, 28'h5, '0, "rd5");
    chk("rd5_data", mem_rdata, 128'd0);

    txn(1'b0, 1'b1, 28'h12, LineD, "wr12");
    chk("wr12_rdata_unchanged", mem_rdata, 128'd0);

    txn(1'b1, 1'b0, 28'h12, '0, "rd12");
    chk("rd12_data", mem_rdata, LineD);

    txn(1'b1, 1'b0, 28'h112, '0, "rd112");
    chk("rd112_alias", mem_rdata, LineD);
    chk("perr_clean", 128'(proto_err), 128'd0);

    // Aborted read: dropped after two WAIT cycles.
    @(negedge clk);
    mem_read = 1'b1;
    mem_addr = 28'h3;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    mem_read = 1'b0;
    hits = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (mem_ready === 1'b1) hits++;
    end
    chk("abort_noready", 128'(hits), 128'd0);
    chk("abort_perr", 128'(proto_err), 128'd1);
    chk("abort_rdata_held", mem_rdata, LineD);

    txn(1'b1, 1'b0, 28'h12, '0, "rd12b");
    chk("rd12b_data", mem_rdata, LineD);

    txn(1'b1, 1'b1, 28'h7, 128'h1, "both7");
    chk("both7_perr", 128'(proto_err), 128'd1);
    chk("both7_rdata_unchanged", mem_rdata, LineD);

    txn(1'b1, 1'b0, 28'h7, '0, "rd7");
    chk("rd7_data", mem_rdata, 128'h1);
    chk("stats_rd", 128'(rd_cnt), 128'(ExpRd));
    chk("stats_wr", 128'(wr_cnt), 128'(ExpWr));

    // Reset in the middle of a write's WAIT phase.
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = 28'h12;
    mem_wdata = LineE;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_write = 1'b0;
    chk("midrst_rdata", mem_rdata, 128'd0);
    chk("midrst_ready", 128'(mem_ready), 128'd0);
    chk("midrst_perr", 128'(proto_err), 128'd0);
    chk("midrst_rdcnt", 128'(rd_cnt), 128'd0);
    chk("midrst_wrcnt", 128'(wr_cnt), 128'd0);
    hits = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (mem_ready === 1'b1) hits++;
    end
    chk("midrst_noready", 128'(hits), 128'd0);

    txn(1'b1, 1'b0, 28'h12, '0, "rd12c");
    chk("rd12c_cleared", mem_rdata, 128'd0);
    chk("rd12c_rdcnt", 128'(rd_cnt), 128'(ExpRdAfter));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
